// File: rtl/cpu_control_unit.sv
// cpu_control_unit
// Multi-cycle control FSM for the 16-bit CPU. Each instruction is fetched
// from memory, the instruction register is loaded, the opcode is decoded and
// the datapath/memory controls are driven until the instruction retires.
//
// State table
//   state       | meaning
//   FETCH   (0) | request instruction word at PC, wait for mem_ack
//   LOAD_IR (1) | load instruction register, PC += 1
//   EXEC    (2) | decode opcode: ALU/LDI/branch/NOP retire, LD/ST go to MEM
//   MEM     (3) | data access at R[SA] for LD/ST, wait for mem_ack
//   HALT    (4) | stopped until reset
//   5..7        | illegal: all outputs 0, return to FETCH
//
// Ports
//   clk_main                in   system clock (posedge)
//   reset                   in   synchronous active-high reset
//   opcode[3:0]             in   opcode from the instruction register
//   alu_z, alu_n            in   ALU zero/negative of the current operation
//   mem_ack                 in   memory completion for the current request
//   il, pc_inc, pc_load     out  IR load, PC increment, PC <= R[SA]
//   rf_we, fs[3:0], mb, md  out  register write, ALU function, B=SB, data=mem
//   mem_req, mem_we         out  memory request (held until ack), write
//   addr_sel                out  memory address: 0 = PC, 1 = R[SA]
//   z_flag, n_flag          out  registered ALU status flags
//   halted                  out  CPU stopped
//   state[2:0]              out  current state (debug)
module cpu_control_unit (
    input  logic       clk_main,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       alu_z,
    input  logic       alu_n,
    input  logic       mem_ack,
    output logic       il,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       rf_we,
    output logic [3:0] fs,
    output logic       mb,
    output logic       md,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       z_flag,
    output logic       n_flag,
    output logic       halted,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_LOAD_IR = 3'd1,
        ST_EXEC    = 3'd2,
        ST_MEM     = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h9;
    localparam logic [3:0] OP_LD  = 4'hA;
    localparam logic [3:0] OP_ST  = 4'hB;
    localparam logic [3:0] OP_BZ  = 4'hC;
    localparam logic [3:0] OP_BN  = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t state_q, state_d;
    logic   flag_upd;

    always_ff @(posedge clk_main) begin
        if (reset) begin
            state_q <= ST_FETCH;
            z_flag  <= 1'b0;
            n_flag  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flag_upd) begin
                z_flag <= alu_z;
                n_flag <= alu_n;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        flag_upd = 1'b0;
        il       = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        rf_we    = 1'b0;
        fs       = 4'h0;
        mb       = 1'b0;
        md       = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        halted   = 1'b0;
        state    = state_q;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = ST_LOAD_IR;
            end
            ST_LOAD_IR: begin
                il      = 1'b1;
                pc_inc  = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                        fs       = opcode;
                        rf_we    = 1'b1;
                        flag_upd = 1'b1;
                    end
                    // fs stays 0 so the ALU passes the zero-extended SB field
                    OP_LDI: begin
                        mb    = 1'b1;
                        rf_we = 1'b1;
                    end
                    OP_LD, OP_ST: state_d = ST_MEM;
                    OP_BZ:  pc_load = z_flag;
                    OP_BN:  pc_load = n_flag;
                    OP_JMP: pc_load = 1'b1;
                    OP_HLT: state_d = ST_HALT;
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (opcode == OP_LD) begin
                    md    = 1'b1;
                    rf_we = mem_ack;
                end
                if (opcode == OP_ST) mem_we = 1'b1;
                if (mem_ack) state_d = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: begin
                state_d = ST_FETCH;
                state   = 3'd0;
            end
        endcase

        // Reset masks every control so an aborted instruction never writes.
        if (reset) begin
            il       = 1'b0;
            pc_inc   = 1'b0;
            pc_load  = 1'b0;
            rf_we    = 1'b0;
            fs       = 4'h0;
            mb       = 1'b0;
            md       = 1'b0;
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 1'b0;
            halted   = 1'b0;
            state    = 3'd0;
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;

    logic       clk_main = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       alu_z = 1'b0;
    logic       alu_n = 1'b0;
    logic       mem_ack = 1'b0;
    logic       il, pc_inc, pc_load, rf_we, mb, md, mem_req, mem_we, addr_sel;
    logic       z_flag, n_flag, halted;
    logic [3:0] fs;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    cpu_control_unit dut (
        .clk_main(clk_main), .reset(reset), .opcode(opcode),
        .alu_z(alu_z), .alu_n(alu_n), .mem_ack(mem_ack),
        .il(il), .pc_inc(pc_inc), .pc_load(pc_load), .rf_we(rf_we),
        .fs(fs), .mb(mb), .md(md), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .z_flag(z_flag), .n_flag(n_flag),
        .halted(halted), .state(state)
    );

    always #5 clk_main = ~clk_main;

    // control bits: il pc_inc pc_load rf_we mb md mem_req mem_we addr_sel halted
    localparam logic [9:0] IL  = 10'h200;
    localparam logic [9:0] PCI = 10'h100;
    localparam logic [9:0] PCL = 10'h080;
    localparam logic [9:0] RFW = 10'h040;
    localparam logic [9:0] MB  = 10'h020;
    localparam logic [9:0] MD  = 10'h010;
    localparam logic [9:0] MRQ = 10'h008;
    localparam logic [9:0] MWE = 10'h004;
    localparam logic [9:0] ASL = 10'h002;
    localparam logic [9:0] HLT = 10'h001;

    // One record per clock cycle: inputs for the cycle and the outputs
    // expected just before the next posedge. exp = {state, ctl, fs, z, n}.
    typedef struct {
        logic        rst;
        logic        ack;
        logic [3:0]  op;
        logic        az;
        logic        an;
        logic [18:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic a, input logic [3:0] o,
                                input logic z_in, input logic n_in, input logic [2:0] st,
                                input logic [9:0] ctl, input logic [3:0] f,
                                input logic z, input logic n);
        vec_t v;
        v.rst = r; v.ack = a; v.op = o; v.az = z_in; v.an = n_in;
        v.exp = {st, ctl, f, z, n};
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [18:0] act;
        @(negedge clk_main);
        reset = v.rst; mem_ack = v.ack; opcode = v.op; alu_z = v.az; alu_n = v.an;
        #2;
        act = {state, il, pc_inc, pc_load, rf_we, mb, md, mem_req, mem_we,
               addr_sel, halted, fs, z_flag, n_flag};
        checks++;
        if (act !== v.exp) begin
            errors++;
            $display("FAIL %s: got {st,ctl,fs,z,n}=%h required %h", name, act, v.exp);
        end
        checks++;
        if (pc_inc && pc_load) begin
            errors++;
            $display("FAIL %s_pc_excl: got pc_inc=%b pc_load=%b required not both 1",
                     name, pc_inc, pc_load);
        end
    endtask

    vec_t tbl[$];

    initial begin
        // reset held: everything reads 0, even with mem_ack high
        tbl.push_back(mk(1,1,4'h0,0,0, 3'd0,10'h0,4'h0,0,0));
        tbl.push_back(mk(1,0,4'h0,0,0, 3'd0,10'h0,4'h0,0,0));
        // ADD, zero-wait fetch, alu_z sets z_flag
        tbl.push_back(mk(0,1,4'h0,0,0, 3'd0,MRQ,4'h0,0,0));
        tbl.push_back(mk(0,1,4'h1,0,0, 3'd1,IL|PCI,4'h0,0,0));
        tbl.push_back(mk(0,1,4'h1,1,0, 3'd2,RFW,4'h1,0,0));
        // fetch with three wait cycles
        tbl.push_back(mk(0,0,4'h1,0,0, 3'd0,MRQ,4'h0,1,0));
        tbl.push_back(mk(0,0,4'h1,0,0, 3'd0,MRQ,4'h0,1,0));
        tbl.push_back(mk(0,0,4'h1,0,0, 3'd0,MRQ,4'h0,1,0));
        tbl.push_back(mk(0,1,4'h1,0,0, 3'd0,MRQ,4'h0,1,0));
        // LD with two wait cycles in MEM
        tbl.push_back(mk(0,1,4'hA,0,0, 3'd1,IL|PCI,4'h0,1,0));
        tbl.push_back(mk(0,1,4'hA,0,0, 3'd2,10'h0,4'h0,1,0));
        tbl.push_back(mk(0,0,4'hA,0,0, 3'd3,MRQ|ASL|MD,4'h0,1,0));
        tbl.push_back(mk(0,0,4'hA,0,0, 3'd3,MRQ|ASL|MD,4'h0,1,0));
        tbl.push_back(mk(0,1,4'hA,0,0, 3'd3,MRQ|ASL|MD|RFW,4'h0,1,0));
        // ST zero wait
        tbl.push_back(mk(0,1,4'hA,0,0, 3'd0,MRQ,4'h0,1,0));
        tbl.push_back(mk(0,1,4'hB,0,0, 3'd1,IL|PCI,4'h0,1,0));
        tbl.push_back(mk(0,1,4'hB,0,0, 3'd2,10'h0,4'h0,1,0));
        tbl.push_back(mk(0,1,4'hB,0,0, 3'd3,MRQ|ASL|MWE,4'h0,1,0));
        // SUB alu_z=1 alu_n=1, then BZ taken
        tbl.push_back(mk(0,1,4'hB,0,0, 3'd0,MRQ,4'h0,1,0));
        tbl.push_back(mk(0,1,4'h2,0,0, 3'd1,IL|PCI,4'h0,1,0));
        tbl.push_back(mk(0,1,4'h2,1,1, 3'd2,RFW,4'h2,1,0));
        tbl.push_back(mk(0,1,4'h2,0,0, 3'd0,MRQ,4'h0,1,1));
        tbl.push_back(mk(0,1,4'hC,0,0, 3'd1,IL|PCI,4'h0,1,1));
        tbl.push_back(mk(0,1,4'hC,0,0, 3'd2,PCL,4'h0,1,1));
        // AND alu_z=0 alu_n=1, then BZ not taken (current alu_z ignored)
        tbl.push_back(mk(0,1,4'hC,0,0, 3'd0,MRQ,4'h0,1,1));
        tbl.push_back(mk(0,1,4'h3,0,0, 3'd1,IL|PCI,4'h0,1,1));
        tbl.push_back(mk(0,1,4'h3,0,1, 3'd2,RFW,4'h3,1,1));
        tbl.push_back(mk(0,1,4'h3,0,0, 3'd0,MRQ,4'h0,0,1));
        tbl.push_back(mk(0,1,4'hC,0,0, 3'd1,IL|PCI,4'h0,0,1));
        tbl.push_back(mk(0,1,4'hC,1,0, 3'd2,10'h0,4'h0,0,1));
        // BN taken
        tbl.push_back(mk(0,1,4'hC,0,0, 3'd0,MRQ,4'h0,0,1));
        tbl.push_back(mk(0,1,4'hD,0,0, 3'd1,IL|PCI,4'h0,0,1));
        tbl.push_back(mk(0,1,4'hD,0,0, 3'd2,PCL,4'h0,0,1));
        // LDI leaves flags alone
        tbl.push_back(mk(0,1,4'hD,0,0, 3'd0,MRQ,4'h0,0,1));
        tbl.push_back(mk(0,1,4'h9,0,0, 3'd1,IL|PCI,4'h0,0,1));
        tbl.push_back(mk(0,1,4'h9,1,0, 3'd2,MB|RFW,4'h0,0,1));
        // JMP unconditional
        tbl.push_back(mk(0,1,4'h9,0,0, 3'd0,MRQ,4'h0,0,1));
        tbl.push_back(mk(0,1,4'hE,0,0, 3'd1,IL|PCI,4'h0,0,1));
        tbl.push_back(mk(0,1,4'hE,0,0, 3'd2,PCL,4'h0,0,1));
        // NOP
        tbl.push_back(mk(0,1,4'hE,0,0, 3'd0,MRQ,4'h0,0,1));
        tbl.push_back(mk(0,1,4'h0,0,0, 3'd1,IL|PCI,4'h0,0,1));
        tbl.push_back(mk(0,1,4'h0,1,1, 3'd2,10'h0,4'h0,0,1));
        // HLT
        tbl.push_back(mk(0,1,4'h0,0,0, 3'd0,MRQ,4'h0,0,1));
        tbl.push_back(mk(0,1,4'hF,0,0, 3'd1,IL|PCI,4'h0,0,1));
        tbl.push_back(mk(0,1,4'hF,0,0, 3'd2,10'h0,4'h0,0,1));

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // HALT holds for 20 cycles with mem_ack pulsing
        for (int i = 0; i < 20; i++)
            apply(mk(0,1'(i % 2),4'hF,0,0, 3'd4,HLT,4'h0,0,1), $sformatf("halt%0d", i));
        // reset leaves HALT; flags clear at that posedge
        apply(mk(1,1,4'hF,0,0, 3'd0,10'h0,4'h0,0,1), "halt_reset");
        apply(mk(0,0,4'hF,0,0, 3'd0,MRQ,4'h0,0,0), "after_halt_fetch");

        // ALU op to set both flags, then ST aborted by reset in MEM
        apply(mk(0,1,4'h0,0,0, 3'd0,MRQ,4'h0,0,0), "abort_fetch0");
        apply(mk(0,1,4'h2,0,0, 3'd1,IL|PCI,4'h0,0,0), "abort_load0");
        apply(mk(0,1,4'h2,1,1, 3'd2,RFW,4'h2,0,0), "abort_exec0");
        apply(mk(0,1,4'h2,0,0, 3'd0,MRQ,4'h0,1,1), "abort_fetch1");
        apply(mk(0,1,4'hB,0,0, 3'd1,IL|PCI,4'h0,1,1), "abort_load1");
        apply(mk(0,1,4'hB,0,0, 3'd2,10'h0,4'h0,1,1), "abort_exec1");
        apply(mk(0,0,4'hB,0,0, 3'd3,MRQ|ASL|MWE,4'h0,1,1), "abort_mem");
        apply(mk(1,1,4'hB,0,0, 3'd0,10'h0,4'h0,1,1), "abort_reset");
        apply(mk(0,0,4'hB,0,0, 3'd0,MRQ,4'h0,0,0), "abort_refetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
